// File: rtl/intersect_unit_nway.sv
// intersect_unit_nway: N-way sorted-stream joiner (intersection or union).
// Lane heads are compared each step; the joined coordinate plus one position
// per lane is pushed into a small output FIFO that drives the outputs.
// Stop/done control tokens pass through once they are aligned on all lanes.

module intersect_unit_nway #(
    parameter int NUM_IN     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clk_en,
    input  logic                                 tile_en,
    input  logic                                 joiner_op,
    input  logic [NUM_IN*(DATA_WIDTH+1)-1:0]     coord_in,
    input  logic [NUM_IN*(DATA_WIDTH+1)-1:0]     pos_in,
    input  logic [NUM_IN-1:0]                    in_valid,
    output logic [NUM_IN-1:0]                    in_ready,
    output logic [DATA_WIDTH:0]                  coord_out,
    output logic [NUM_IN*(DATA_WIDTH+1)-1:0]     pos_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 done_pulse,
    output logic [15:0]                          tile_count,
    output logic                                 err
);

    localparam int W  = DATA_WIDTH + 1;
    localparam int PW = NUM_IN * W;
    localparam int EW = PW + W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [DATA_WIDTH-1:0] DONE_PAY  = DATA_WIDTH'(16'h0100);
    localparam logic [DATA_WIDTH-1:0] EMPTY_PAY = DATA_WIDTH'(16'h0200);
    localparam logic [W-1:0]          DONE_WORD  = {1'b1, DONE_PAY};
    localparam logic [W-1:0]          EMPTY_WORD = {1'b1, EMPTY_PAY};
    localparam logic [AW-1:0]         PTR_ONE    = AW'(1);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [15:0]           TC_MAX     = 16'hFFFF;
    localparam logic [15:0]           TC_ONE     = 16'h0001;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                 state_r;
    logic [EW-1:0]          mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [EW-1:0]          last_r;
    logic                   op_r;
    logic                   op_open_r;
    logic                   err_r;
    logic [15:0]            tile_count_r;
    logic                   done_pulse_r;

    logic [NUM_IN-1:0]      head_ctrl_s;
    logic [DATA_WIDTH-1:0]  head_pay_s [NUM_IN];
    logic [DATA_WIDTH-1:0]  min_s;
    logic                   any_data_s;
    logic [NUM_IN-1:0]      eq_m_s;
    logic                   tok_same_s;
    logic                   all_ctrl_s;
    logic                   all_data_s;
    logic                   op_s;
    logic                   push_want_s;
    logic [NUM_IN-1:0]      pop_mask_s;
    logic [W-1:0]           push_coord_s;
    logic [PW-1:0]          push_pos_s;
    logic                   mismatch_s;
    logic                   done_tok_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   step_s;
    logic                   push_s;
    logic                   pop_s;
    logic [EW-1:0]          head_s;
    logic [EW-1:0]          shown_s;

    // Split each lane head into its control flag and payload.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            head_ctrl_s[i] = coord_in[i*W + DATA_WIDTH];
            head_pay_s[i]  = coord_in[i*W +: DATA_WIDTH];
        end
    end

    // Minimum coordinate over the data lanes.
    always_comb begin
        min_s      = '1;
        any_data_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!head_ctrl_s[i] && (!any_data_s || (head_pay_s[i] < min_s))) begin
                min_s      = head_pay_s[i];
                any_data_s = 1'b1;
            end else begin
                min_s      = min_s;
                any_data_s = any_data_s;
            end
        end
    end

    // Lanes at the minimum, and whether all control heads carry one token.
    always_comb begin
        eq_m_s     = '0;
        tok_same_s = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            eq_m_s[i] = !head_ctrl_s[i] && (head_pay_s[i] == min_s);
            if (coord_in[i*W +: W] != coord_in[W-1:0]) begin
                tok_same_s = 1'b0;
            end else begin
                tok_same_s = tok_same_s;
            end
        end
    end

    assign all_ctrl_s = &head_ctrl_s;
    assign all_data_s = ~|head_ctrl_s;
    // Op is taken live at a tile start and held from the latch afterwards.
    assign op_s       = op_open_r ? joiner_op : op_r;

    // Join decision: what to push and which lanes to pop.
    always_comb begin
        push_want_s  = 1'b0;
        pop_mask_s   = '0;
        push_coord_s = '0;
        push_pos_s   = '0;
        mismatch_s   = 1'b0;
        done_tok_s   = 1'b0;
        case ({all_ctrl_s, op_s})
            2'b10, 2'b11: begin
                // All lanes at a token: forward lane 0's token everywhere.
                push_want_s  = 1'b1;
                pop_mask_s   = '1;
                push_coord_s = coord_in[W-1:0];
                for (int i = 0; i < NUM_IN; i++) begin
                    push_pos_s[i*W +: W] = coord_in[W-1:0];
                end
                mismatch_s = !tok_same_s;
                done_tok_s = (coord_in[W-1:0] == DONE_WORD);
            end
            2'b00: begin
                if (all_data_s && (&eq_m_s)) begin
                    push_want_s  = 1'b1;
                    pop_mask_s   = '1;
                    push_coord_s = {1'b0, min_s};
                    push_pos_s   = pos_in;
                end else if (all_data_s) begin
                    pop_mask_s = eq_m_s;
                end else begin
                    // Lanes still holding data cannot match a finished lane.
                    pop_mask_s = ~head_ctrl_s;
                end
            end
            2'b01: begin
                push_want_s  = any_data_s;
                pop_mask_s   = eq_m_s;
                push_coord_s = {1'b0, min_s};
                for (int i = 0; i < NUM_IN; i++) begin
                    if (eq_m_s[i]) begin
                        push_pos_s[i*W +: W] = pos_in[i*W +: W];
                    end else begin
                        push_pos_s[i*W +: W] = EMPTY_WORD;
                    end
                end
            end
            default: begin
                push_want_s = 1'b0;
            end
        endcase
    end

    assign full_s   = (count_r == CNT_FULL);
    assign empty_s  = (count_r == '0);
    assign step_s   = !rst && (state_r == RUN) && clk_en && tile_en && (&in_valid) && !full_s;
    assign push_s   = step_s && push_want_s;
    assign pop_s    = clk_en && tile_en && !empty_s && out_ready;
    assign in_ready = step_s ? pop_mask_s : '0;

    assign head_s     = mem_r[rd_ptr_r];
    // An empty FIFO keeps showing the last word that left it.
    assign shown_s    = empty_s ? last_r : head_s;
    assign coord_out  = shown_s[W-1:0];
    assign pos_out    = shown_s[EW-1:W];
    assign out_valid  = tile_en && !empty_s;
    assign done_pulse = done_pulse_r;
    assign tile_count = tile_count_r;
    assign err        = err_r;

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {push_pos_s, push_coord_s};
        end
    end

    // FIFO pointers, FSM, op latch, error flag and tile counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RUN;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            last_r       <= '0;
            op_r         <= 1'b0;
            op_open_r    <= 1'b1;
            err_r        <= 1'b0;
            tile_count_r <= '0;
            done_pulse_r <= 1'b0;
        end else if (clk_en) begin
            done_pulse_r <= 1'b0;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                last_r   <= head_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (step_s && op_open_r) begin
                op_r      <= joiner_op;
                op_open_r <= 1'b0;
            end
            if (push_s && mismatch_s) begin
                err_r <= 1'b1;
            end
            if (push_s && !push_coord_s[DATA_WIDTH] && (tile_count_r != TC_MAX)) begin
                tile_count_r <= tile_count_r + TC_ONE;
            end
            case (state_r)
                RUN: begin
                    if (push_s && done_tok_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_s && (head_s[W-1:0] == DONE_WORD)) begin
                        state_r      <= RUN;
                        done_pulse_r <= 1'b1;
                        tile_count_r <= '0;
                        op_open_r    <= 1'b1;
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_intersect_unit_nway.sv
// Directed bench for intersect_unit_nway (3 lanes). Lane drivers pop their
// stimulus tables on in_ready; expected words go into a scoreboard queue and
// a separate monitor compares each word accepted on the output.

module tb_intersect_unit_nway;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int W  = DW + 1;

    localparam logic [W-1:0] S0 = 17'h10000;
    localparam logic [W-1:0] S1 = 17'h10001;
    localparam logic [W-1:0] DN = 17'h10100;
    localparam logic [W-1:0] ER = 17'h10200;

    logic           clk = 1'b0;
    logic           rst;
    logic           clk_en;
    logic           tile_en;
    logic           joiner_op;
    logic [N*W-1:0] coord_in;
    logic [N*W-1:0] pos_in;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   coord_out;
    logic [N*W-1:0] pos_out;
    logic           out_valid;
    logic           out_ready;
    logic           done_pulse;
    logic [15:0]    tile_count;
    logic           err;

    intersect_unit_nway #(.NUM_IN(N), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .tile_en(tile_en),
        .joiner_op(joiner_op), .coord_in(coord_in), .pos_in(pos_in),
        .in_valid(in_valid), .in_ready(in_ready), .coord_out(coord_out),
        .pos_out(pos_out), .out_valid(out_valid), .out_ready(out_ready),
        .done_pulse(done_pulse), .tile_count(tile_count), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0]   lane_c [N][16];
    logic [W-1:0]   lane_p [N][16];
    int             lane_len [N];
    int             lane_idx [N];
    logic [N-1:0]   drv_mask;

    logic [W-1:0]   exp_c [$];
    logic [N*W-1:0] exp_p [$];
    int             exp_tc [$];

    int acc_cnt       = 0;
    int pulse_cnt     = 0;
    bit pulse_pending = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] d(input int v);
        return {1'b0, 16'(v)};
    endfunction

    function automatic logic [W-1:0] posv(input int ln, input int k);
        logic [15:0] v;
        v = 16'hA000 + 16'(ln * 256 + k);
        return {1'b0, v};
    endfunction

    task automatic put(input int ln, input logic [W-1:0] c);
        lane_c[ln][lane_len[ln]] = c;
        lane_p[ln][lane_len[ln]] = c[DW] ? c : posv(ln, lane_len[ln]);
        lane_len[ln]++;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < N; i++) begin
            lane_len[i] = 0;
            lane_idx[i] = 0;
        end
    endtask

    task automatic expect_word(input logic [W-1:0] c, input logic [W-1:0] p0,
                               input logic [W-1:0] p1, input logic [W-1:0] p2, input int tc);
        exp_c.push_back(c);
        exp_p.push_back({p2, p1, p0});
        exp_tc.push_back(tc);
    endtask

    task automatic wait_drain(input string nm);
        int cyc;
        bit busy;
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 300) begin
            @(posedge clk);
            cyc++;
            busy = (exp_c.size() != 0);
            for (int i = 0; i < N; i++) begin
                if (lane_idx[i] < lane_len[i]) busy = 1'b1;
            end
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d words still outstanding, required 0", nm, exp_c.size());
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Lane drivers: pop on the in_ready seen before the edge, then present next head.
    initial begin
        in_valid = '0;
        coord_in = '0;
        pos_in   = '0;
        forever begin
            @(negedge clk);
            drv_mask = in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (drv_mask[i] && lane_idx[i] < lane_len[i]) lane_idx[i]++;
                if (lane_idx[i] < lane_len[i]) begin
                    in_valid[i]          = 1'b1;
                    coord_in[i*W +: W]   = lane_c[i][lane_idx[i]];
                    pos_in[i*W +: W]     = lane_p[i][lane_idx[i]];
                end else begin
                    in_valid[i]          = 1'b0;
                    coord_in[i*W +: W]   = '0;
                    pos_in[i*W +: W]     = '0;
                end
            end
        end
    end

    // Monitor: compare every accepted output word against the scoreboard.
    always @(negedge clk) begin
        if (pulse_pending) begin
            chk("done_pulse_after_done", 64'(done_pulse), 64'(1'b1));
            pulse_pending = 1'b0;
        end
        if (done_pulse) pulse_cnt++;
        if (out_valid && out_ready) begin
            if (exp_c.size() == 0) begin
                chk("unexpected_output", 64'(coord_out), 64'(17'h1FFFF));
            end else begin
                logic [W-1:0]   ec;
                logic [N*W-1:0] ep;
                int             et;
                ec = exp_c.pop_front();
                ep = exp_p.pop_front();
                et = exp_tc.pop_front();
                chk("coord_out", 64'(coord_out), 64'(ec));
                chk("pos_out", 64'(pos_out), 64'(ep));
                if (et >= 0) chk("tile_count_at_done", 64'(tile_count), 64'(et));
                if (ec == DN) pulse_pending = 1'b1;
            end
            acc_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int base;
        int cyc;
        rst       = 1'b1;
        clk_en    = 1'b1;
        tile_en   = 1'b1;
        joiner_op = 1'b0;
        out_ready = 1'b1;
        clear_lanes();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_coord_out", 64'(coord_out), 64'(17'h0));
        chk("rst_pos_out", 64'(pos_out), 64'(51'h0));
        chk("rst_done_pulse", 64'(done_pulse), 64'(1'b0));
        chk("rst_tile_count", 64'(tile_count), 64'(16'h0));
        chk("rst_err", 64'(err), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(3'b000));

        // Intersect
        @(posedge clk);
        #2;
        p0 = pulse_cnt;
        clear_lanes();
        put(0, d(1)); put(0, d(3)); put(0, d(5)); put(0, S0); put(0, DN);
        put(1, d(3)); put(1, d(5)); put(1, d(7)); put(1, S0); put(1, DN);
        put(2, d(0)); put(2, d(3)); put(2, d(5)); put(2, S0); put(2, DN);
        expect_word(d(3), posv(0, 1), posv(1, 0), posv(2, 1), -1);
        expect_word(d(5), posv(0, 2), posv(1, 1), posv(2, 2), -1);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 2);
        wait_drain("intersect");
        chk("intersect_pulses", 64'(pulse_cnt - p0), 64'(1));

        // Union
        joiner_op = 1'b1;
        p0 = pulse_cnt;
        clear_lanes();
        put(0, d(1)); put(0, d(4)); put(0, S0); put(0, DN);
        put(1, d(2)); put(1, d(4)); put(1, S0); put(1, DN);
        put(2, d(2)); put(2, S0); put(2, DN);
        expect_word(d(1), posv(0, 0), ER, ER, -1);
        expect_word(d(2), ER, posv(1, 0), posv(2, 0), -1);
        expect_word(d(4), posv(0, 1), posv(1, 1), ER, -1);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 3);
        wait_drain("union");
        chk("union_pulses", 64'(pulse_cnt - p0), 64'(1));
        joiner_op = 1'b0;

        // Backpressure
        out_ready = 1'b0;
        clear_lanes();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) put(i, d(k + 1));
            put(i, S0);
            put(i, DN);
        end
        for (int k = 0; k < 4; k++) expect_word(d(k + 1), posv(0, k), posv(1, k), posv(2, k), -1);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 4);
        repeat (5) @(negedge clk);
        chk("bp_in_ready_full", 64'(in_ready), 64'(3'b000));
        chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
        chk("bp_buffered", 64'(tile_count), 64'(16'd2));
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain("backpressure");

        // Token mismatch
        clear_lanes();
        put(0, S0); put(0, DN);
        put(1, S1); put(1, DN);
        put(2, S0); put(2, DN);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 0);
        wait_drain("mismatch");
        chk("mismatch_err", 64'(err), 64'(1'b1));

        // Reset mid-stream
        clear_lanes();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 6; k++) put(i, d(k + 1));
            put(i, S0);
            put(i, DN);
        end
        for (int k = 0; k < 6; k++) expect_word(d(k + 1), posv(0, k), posv(1, k), posv(2, k), -1);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 6);
        base = acc_cnt;
        cyc  = 0;
        while (acc_cnt < base + 2 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        chk("rst_mid_two_outputs", 64'(acc_cnt - base >= 2), 64'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_mid_err", 64'(err), 64'(1'b0));
        chk("rst_mid_tile_count", 64'(tile_count), 64'(16'h0));
        exp_c.delete();
        exp_p.delete();
        exp_tc.delete();
        clear_lanes();
        @(posedge clk);
        #2;
        rst = 1'b0;
        p0 = pulse_cnt;
        put(0, d(2)); put(0, d(4)); put(0, S0); put(0, DN);
        put(1, d(4)); put(1, S0); put(1, DN);
        put(2, d(1)); put(2, d(4)); put(2, S0); put(2, DN);
        expect_word(d(4), posv(0, 1), posv(1, 0), posv(2, 1), -1);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 1);
        wait_drain("after_reset");
        chk("after_reset_pulses", 64'(pulse_cnt - p0), 64'(1));

        // Gating
        clear_lanes();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) put(i, d(k + 1));
            put(i, S0);
            put(i, DN);
        end
        for (int k = 0; k < 4; k++) expect_word(d(k + 1), posv(0, k), posv(1, k), posv(2, k), -1);
        expect_word(S0, S0, S0, S0, -1);
        expect_word(DN, DN, DN, DN, 4);
        repeat (3) @(posedge clk);
        #2;
        tile_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gate_in_ready", 64'(in_ready), 64'(3'b000));
            chk("gate_out_valid", 64'(out_valid), 64'(1'b0));
        end
        @(posedge clk);
        #2;
        tile_en = 1'b1;
        wait_drain("gating");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/intersect_unit_nway.md
# intersect_unit_nway

N-way sparse-stream joiner: merges NUM_IN sorted coordinate streams, each with a matching position (reference) stream, into one coordinate stream plus NUM_IN position streams. It performs either intersection or union and propagates stop/done control tokens. It is the parametrised successor of the two-input intersect unit. It sits between level scanners and downstream ALU/reduce stages in the sparse tile.

## Interface
Parameters:
- NUM_IN, 3: number of input lanes (2..4).
- DATA_WIDTH, 16: payload width. Each stream word is W = DATA_WIDTH+1 bits; bit DATA_WIDTH = 1 marks a control word.
- FIFO_DEPTH, 2: output buffer entries (power of 2, >= 2).

Control-word payload encoding:
- 0x000..0x0FF = stop token S(level).
- 0x100 = done.
- 0x200 = empty-ref, emitted on position lanes only.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
- clk_en  in  1  gates all state updates.
- tile_en  in  1  block enable; low = inert.
- joiner_op  in  1  0 = intersect, 1 = union; sampled only in state RUN at a tile start (first pop after reset or after done).
- coord_in  in  NUM_IN*W  packed head coordinates, lane i at [i*W +: W].
- pos_in  in  NUM_IN*W  packed positions.
- in_valid  in  NUM_IN  lane i has coord_in[i] and pos_in[i] valid.
- in_ready  out  NUM_IN  lane i popped this cycle.
- coord_out  out  W  output coordinate/token.
- pos_out  out  NUM_IN*W  output positions.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts (shared by coord and all pos outputs).
- done_pulse  out  1  one-cycle pulse when done is accepted downstream.
- tile_count  out  16  data words emitted in the current tile.
- err  out  1  sticky token-mismatch flag.

## Operation
- FSM states: RUN and DRAIN.
  - RUN: join decisions are made.
  - DRAIN: entered when done is pushed to the FIFO. All in_ready are 0 until done leaves the FIFO. Then done_pulse is asserted, tile_count clears, the op latch re-opens, and the FSM returns to RUN.
- Step condition: state RUN, clk_en, tile_en, all in_valid high, and FIFO not full. Otherwise all in_ready = 0.
- Let D = set of lanes whose head is data, and m = min coord over D (unsigned).
- All heads data, intersect:
  - If all heads equal m: push (m, all pos) and pop all lanes.
  - Else pop only the lanes whose head equals m; push nothing.
- All heads data, union:
  - Push m; pos[i] = pos_in[i] for lanes with head equal to m, and empty-ref for the other lanes.
  - Pop the lanes whose head equals m.
- Mixed data and control heads:
  - Intersect: pop all lanes in D; push nothing.
  - Union: same as the all-data union case, restricted to D. Control lanes get empty-ref and are not popped.
- All heads control:
  - If all tokens are identical: push the token on coord_out and on every pos lane; pop all.
  - If tokens differ: set err, push lane 0's token, pop all.
  - If the token is done: enter DRAIN.
- tile_count increments for each data word pushed and saturates at 0xFFFF.
- tile_en low:
  - in_ready = 0 and out_valid = 0.
  - FIFO, FSM and counters hold their state.
- clk_en low: nothing updates. Outputs are unchanged and in_ready = 0.

## Timing
- Reset values:
  - Outputs: in_ready 0, out_valid 0, coord_out 0, pos_out 0, done_pulse 0, tile_count 0, err 0.
  - State: FSM RUN, FIFO empty.
- in_ready is combinational from the in_valid values, the head words and FIFO fullness. It is legal for ready to depend on valid.
- Latency: a word pushed in cycle N is visible on out_valid in cycle N+1. Outputs are driven from FIFO registers.
- Full throughput: one pushed word per cycle while out_ready stays high.
- FIFO full: pushes stall, and in_ready stays 0 until a pop frees an entry. A push and a pop in the same cycle on a full FIFO is not allowed (step condition uses "not full").
- FIFO empty: out_valid = 0 and coord_out holds its last value.
- done_pulse is asserted in the cycle after done is accepted (out_valid && out_ready).
- Reset asserted mid-stream clears FIFO, FSM, err and tile_count immediately. Words in flight are discarded.

## Test plan
- Intersect, NUM_IN=3:
  - Stimulus: lanes {1,3,5,S0,D}, {3,5,7,S0,D}, {0,3,5,S0,D}.
  - Required: coord_out = 3, 5, S0, D with the matching positions; done_pulse once; tile_count = 2.
- Union, NUM_IN=2:
  - Stimulus: {1,4,S0,D} and {2,4,S0,D}.
  - Required: coords 1, 2, 4, S0, D; pos_out lane 1 = empty-ref (0x10200) for coord 1, lane 0 = empty-ref for coord 2.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles during the intersect stream.
  - Required: at most FIFO_DEPTH words buffered; in_ready = 0 once the FIFO is full; no loss or duplication after release.
- Token mismatch:
  - Stimulus: lane heads S0 and S1 simultaneously.
  - Required: err = 1 (sticky), S0 emitted, all lanes popped.
- Reset mid-stream:
  - Stimulus: assert rst after 2 outputs.
  - Required: out_valid drops in the same cycle; err = 0 and tile_count = 0; a fresh stream then joins correctly.
- Gating:
  - Stimulus: tile_en low for 3 cycles mid-stream.
  - Required: no pops and out_valid = 0; identical output sequence once re-enabled.
